// File: rtl/led_anim_pkg.sv
// led_anim_pkg: shared widths, LED blank word and sequencer state encoding
package led_anim_pkg;
    localparam int FRAME_W = 7;
    localparam int LED_W = 7;
    localparam int SPD_W = 2;
    localparam logic [LED_W-1:0] LED_OFF = 7'b1111111;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: programmable prescale divider producing one frame tick per PRESCALE<<speed enabled cycles
module led_tick_gen
    import led_anim_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [SPD_W-1:0] speed,
    output logic             tick
);
    localparam int PRE_W = $clog2(PRESCALE);
    localparam int CNT_W = PRE_W + 3;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_term;

    // terminal is recomputed every cycle so a speed change applies at once;
    // a count already past a shorter terminal ticks and wraps immediately
    assign w_term = CNT_W'((PRESCALE << speed) - 1);
    assign tick   = en && !clr && (r_cnt >= w_term);

    // divider: clear wins over enable, wrap to zero on tick
    always_ff @(posedge clk) begin
        if (rst || clr)
            r_cnt <= '0;
        else if (en)
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/led_anim_seq.sv
// led_anim_seq: LED animation frame sequencer (play/pause/stop/loop/one-shot).
// Optional ping-pong playback is enabled by defining LED_ANIM_PINGPONG_EN.
module led_anim_seq
    import led_anim_pkg::*;
#(
    parameter int PRESCALE   = 50000,
    parameter int NUM_PAT    = 16,
    parameter int PAT_W      = 4,
    parameter int LAST_FRAME = 127
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
`ifdef LED_ANIM_PINGPONG_EN
    input  logic               pingpong,
`endif
    input  logic [SPD_W-1:0]   speed,
    input  logic [PAT_W-1:0]   pat_sel,
    input  logic [LED_W-1:0]   rom_data,
    output logic [FRAME_W-1:0] frame_idx,
    output logic [PAT_W-1:0]   pat_idx,
    output logic [LED_W-1:0]   led_n,
    output logic               busy,
    output logic               done
);
    localparam logic [FRAME_W-1:0] LAST = FRAME_W'(LAST_FRAME);

    state_t             r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [PAT_W-1:0]   r_pat;
    logic [LED_W-1:0]   r_led;
    logic               r_busy;
    logic               r_done;
`ifdef LED_ANIM_PINGPONG_EN
    logic               r_dir;
`endif
    logic               w_en;
    logic               w_clr;
    logic               w_tick;
    logic [PAT_W-1:0]   w_pat;

    // divider runs only while playing and no higher-priority control is active
    assign w_en  = (r_state == RUN) && !pause && !stop && !start;
    assign w_clr = stop || start;
    // out-of-range selections fall back to pattern 0
    assign w_pat = (int'(pat_sel) < NUM_PAT) ? pat_sel : '0;

    led_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .clr  (w_clr),
        .speed(speed),
        .tick (w_tick)
    );

    // playback FSM with registered frame, pattern, LED, busy and done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_pat   <= '0;
            r_led   <= LED_OFF;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
            r_dir   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_led  <= (stop || r_state == IDLE) ? LED_OFF : rom_data;
            if (stop) begin
                r_state <= IDLE;
                r_frame <= '0;
                r_busy  <= 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
                r_dir   <= 1'b0;
`endif
            end else if (start) begin
                r_state <= RUN;
                r_frame <= '0;
                r_pat   <= w_pat;
                r_busy  <= 1'b1;
`ifdef LED_ANIM_PINGPONG_EN
                r_dir   <= 1'b0;
`endif
            end else if (r_state == RUN && pause) begin
                r_state <= PAUSE;
            end else if (r_state == PAUSE && !pause) begin
                r_state <= RUN;
            end else if (w_tick) begin
`ifdef LED_ANIM_PINGPONG_EN
                if (r_dir) begin
                    if (r_frame != '0)
                        r_frame <= r_frame - 1'b1;
                    if (r_frame <= FRAME_W'(1))
                        r_dir <= 1'b0;
                    if (r_frame == FRAME_W'(1) && !loop_en) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end else if (r_frame == LAST && pingpong) begin
                    r_dir   <= 1'b1;
                    r_frame <= LAST - 1'b1;
                end else
`endif
                if (r_frame != LAST)
                    r_frame <= r_frame + 1'b1;
                else if (loop_en)
                    r_frame <= '0;
                else begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign frame_idx = r_frame;
    assign pat_idx   = r_pat;
    assign led_n     = r_led;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_led_anim_seq.sv
// tb_led_anim_seq: randomized self-checking bench against a cycle-level playback model
module tb_led_anim_seq;
    localparam int PRESCALE = 4;
    localparam int LAST = 127;

    logic clk = 1'b0;
    logic rst, start, stop, pause, loop_en;
    logic [1:0] speed;
    logic [3:0] pat_sel, pat_idx;
    logic [6:0] rom_data, frame_idx, led_n;
    logic busy, done;
`ifdef LED_ANIM_PINGPONG_EN
    logic pingpong;
`endif

    int checks = 0;
    int failures = 0;
    int dut_done_cnt = 0;

    // model: mode 0 idle, 1 run, 2 pause, 3 done; ph = cycles elapsed in current frame period
    int m_mode, m_frame, m_pat, m_ph, m_dir;
    logic [6:0] m_led;
    logic m_busy, m_done;

    always #5 clk = ~clk;

    function automatic logic [6:0] rom(int f, int p);
        return 7'(f * 37 + p * 11 + 5) ^ 7'(f >> 3);
    endfunction

    assign rom_data = rom(int'(frame_idx), int'(pat_idx));

    led_anim_seq #(.PRESCALE(PRESCALE), .NUM_PAT(16), .PAT_W(4), .LAST_FRAME(LAST)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .loop_en(loop_en),
`ifdef LED_ANIM_PINGPONG_EN
        .pingpong(pingpong),
`endif
        .speed(speed), .pat_sel(pat_sel), .rom_data(rom_data), .frame_idx(frame_idx),
        .pat_idx(pat_idx), .led_n(led_n), .busy(busy), .done(done)
    );

    task automatic step();
        int period;
        logic pp;
        period = PRESCALE << speed;
        pp = 1'b0;
`ifdef LED_ANIM_PINGPONG_EN
        pp = pingpong;
`endif
        if (rst) begin
            m_mode = 0; m_frame = 0; m_pat = 0; m_ph = 0; m_dir = 0;
            m_led = 7'h7F; m_busy = 0; m_done = 0;
        end else begin
            m_led = (!stop && m_mode != 0) ? rom(m_frame, m_pat) : 7'h7F;
            m_done = 0;
            if (stop) begin
                m_mode = 0; m_frame = 0; m_ph = 0; m_dir = 0;
            end else if (start) begin
                m_mode = 1; m_frame = 0; m_ph = 0; m_dir = 0; m_pat = int'(pat_sel);
            end else if (m_mode == 1 && pause) m_mode = 2;
            else if (m_mode == 2 && !pause) m_mode = 1;
            else if (m_mode == 1) begin
                if (m_ph + 1 < period) m_ph++;
                else begin
                    m_ph = 0;
                    if (m_dir == 1) begin
                        if (m_frame > 0) begin
                            m_frame--;
                            if (m_frame == 0) begin
                                m_dir = 0;
                                if (!loop_en) begin m_mode = 3; m_done = 1; end
                            end
                        end else m_dir = 0;
                    end else if (m_frame < LAST) m_frame++;
                    else if (pp) begin m_dir = 1; m_frame = LAST - 1; end
                    else if (loop_en) m_frame = 0;
                    else begin m_mode = 3; m_done = 1; end
                end
            end
            m_busy = (m_mode == 1 || m_mode == 2);
        end
        @(posedge clk);
        #1;
        if (done === 1'b1) dut_done_cnt++;
    endtask

    task automatic test_reset();
        rst = 1; step(); step();
        checks++;
        if ({frame_idx, pat_idx, led_n, busy, done} !== {7'h00, 4'h0, 7'h7F, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset f/p/led/b/d got %0d/%0d/%h/%b/%b exp 0/0/7f/0/0", frame_idx, pat_idx, led_n, busy, done);
        end
        rst = 0;
        for (int i = 0; i < 20; i++) begin
            pause = 1'($urandom); loop_en = 1'($urandom); speed = 2'($urandom); pat_sel = 4'($urandom);
            step();
            checks++;
            if ({frame_idx, pat_idx, led_n, busy, done} !== {7'(m_frame), 4'(m_pat), m_led, m_busy, m_done}) begin
                failures++;
                $display("FAIL idle_hold f/p/led/b/d got %0d/%0d/%h/%b/%b exp %0d/%0d/%h/%b/%b", frame_idx, pat_idx, led_n, busy, done, m_frame, m_pat, m_led, m_busy, m_done);
            end
        end
        pause = 0;
    endtask

    task automatic test_loop();
        int d0;
        loop_en = 1; speed = 0; pat_sel = 3; start = 1; step(); start = 0;
        checks++;
        if ({pat_idx, busy, frame_idx} !== {4'd3, 1'b1, 7'd0}) begin
            failures++;
            $display("FAIL loop_start pat/busy/frame got %0d/%b/%0d exp 3/1/0", pat_idx, busy, frame_idx);
        end
        d0 = dut_done_cnt;
        for (int i = 0; i < 128 * 4 + 12; i++) begin
            pat_sel = 4'($urandom);
            step();
            checks++;
            if ({frame_idx, pat_idx, led_n, busy, done} !== {7'(m_frame), 4'(m_pat), m_led, m_busy, m_done}) begin
                failures++;
                $display("FAIL loop_run f/p/led/b/d got %0d/%0d/%h/%b/%b exp %0d/%0d/%h/%b/%b", frame_idx, pat_idx, led_n, busy, done, m_frame, m_pat, m_led, m_busy, m_done);
            end
        end
        checks++;
        if (dut_done_cnt != d0 || frame_idx > 7'd5) begin
            failures++;
            $display("FAIL loop_wrap done_pulses=%0d frame=%0d exp 0 pulses, frame<=5 after wrap", dut_done_cnt - d0, frame_idx);
        end
    endtask

    task automatic test_oneshot();
        int d0, n;
        loop_en = 0; speed = 1; pat_sel = 4'($urandom); start = 1; step(); start = 0;
        d0 = dut_done_cnt; n = 0;
        while (m_mode != 3 && n < 3000) begin
            step(); n++;
            checks++;
            if ({frame_idx, pat_idx, led_n, busy, done} !== {7'(m_frame), 4'(m_pat), m_led, m_busy, m_done}) begin
                failures++;
                $display("FAIL oneshot f/p/led/b/d got %0d/%0d/%h/%b/%b exp %0d/%0d/%h/%b/%b", frame_idx, pat_idx, led_n, busy, done, m_frame, m_pat, m_led, m_busy, m_done);
            end
        end
        checks++;
        if (n != 128 * 8) begin
            failures++;
            $display("FAIL oneshot_len cycles=%0d exp %0d", n, 128 * 8);
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (dut_done_cnt - d0 != 1 || frame_idx !== 7'd127 || busy !== 1'b0 || led_n !== rom(127, m_pat)) begin
            failures++;
            $display("FAIL oneshot_end pulses=%0d frame=%0d busy=%b led=%h exp 1/127/0/%h", dut_done_cnt - d0, frame_idx, busy, led_n, rom(127, m_pat));
        end
    endtask

    task automatic test_pause();
        int n;
        logic [6:0] led_hold;
        loop_en = 1; speed = 0; pat_sel = 4'($urandom); start = 1; step(); start = 0;
        n = 0;
        while (!(m_frame == 10 && m_ph == 2) && n < 200) begin step(); n++; end
        checks++;
        if (n >= 200 || frame_idx !== 7'd10) begin
            failures++;
            $display("FAIL pause_reach frame=%0d exp 10 within budget", frame_idx);
        end
        pause = 1; step(); led_hold = led_n;
        for (int i = 0; i < 29; i++) begin
            step();
            checks++;
            if (frame_idx !== 7'd10 || led_n !== led_hold || busy !== 1'b1) begin
                failures++;
                $display("FAIL pause_hold frame=%0d led=%h busy=%b exp 10/%h/1", frame_idx, led_n, busy, led_hold);
            end
        end
        pause = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({frame_idx, pat_idx, led_n, busy, done} !== {7'(m_frame), 4'(m_pat), m_led, m_busy, m_done}) begin
                failures++;
                $display("FAIL pause_resume f/p/led/b/d got %0d/%0d/%h/%b/%b exp %0d/%0d/%h/%b/%b", frame_idx, pat_idx, led_n, busy, done, m_frame, m_pat, m_led, m_busy, m_done);
            end
        end
        checks++;
        if (frame_idx !== 7'd11) begin
            failures++;
            $display("FAIL pause_next frame=%0d exp 11", frame_idx);
        end
    endtask

    task automatic test_stop_start();
        for (int i = 0; i < 9; i++) step();
        stop = 1; start = 1; pat_sel = 4'd9; step(); stop = 0; start = 0;
        checks++;
        if (led_n !== 7'h7F || busy !== 1'b0 || frame_idx !== 7'd0) begin
            failures++;
            $display("FAIL stop_wins led=%h busy=%b frame=%0d exp 7f/0/0", led_n, busy, frame_idx);
        end
        for (int i = 0; i < 5; i++) step();
        pat_sel = 5; start = 1; step(); start = 0;
        for (int i = 0; i < 200; i++) begin
            pat_sel = 4'($urandom);
            step();
            checks++;
            if ({frame_idx, pat_idx, led_n, busy, done} !== {7'(m_frame), 4'(m_pat), m_led, m_busy, m_done}) begin
                failures++;
                $display("FAIL patsel_run f/p/led/b/d got %0d/%0d/%h/%b/%b exp %0d/%0d/%h/%b/%b", frame_idx, pat_idx, led_n, busy, done, m_frame, m_pat, m_led, m_busy, m_done);
            end
        end
        checks++;
        if (pat_idx !== 4'd5) begin
            failures++;
            $display("FAIL patsel_latch pat=%0d exp 5", pat_idx);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom % 300) == 0;
            stop = ($urandom % 700) == 0;
            if ($urandom % 25 == 0) pause = ~pause;
            if ($urandom % 30 == 0) speed = 2'($urandom);
            if ($urandom % 200 == 0) loop_en = ~loop_en;
`ifdef LED_ANIM_PINGPONG_EN
            if ($urandom % 300 == 0) pingpong = ~pingpong;
`endif
            pat_sel = 4'($urandom);
            step();
            checks++;
            if ({frame_idx, pat_idx, led_n, busy, done} !== {7'(m_frame), 4'(m_pat), m_led, m_busy, m_done}) begin
                failures++;
                $display("FAIL random cyc=%0d f/p/led/b/d got %0d/%0d/%h/%b/%b exp %0d/%0d/%h/%b/%b", i, frame_idx, pat_idx, led_n, busy, done, m_frame, m_pat, m_led, m_busy, m_done);
            end
        end
        start = 0; stop = 0; pause = 0;
    endtask

`ifdef LED_ANIM_PINGPONG_EN
    task automatic test_pingpong();
        int d0, n, peak;
        stop = 1; step(); stop = 0;
        pingpong = 1; loop_en = 0; speed = 0; start = 1; step(); start = 0;
        d0 = dut_done_cnt; n = 0; peak = 0;
        while (m_mode != 3 && n < 2000) begin
            step(); n++;
            if (int'(frame_idx) > peak) peak = int'(frame_idx);
            checks++;
            if ({frame_idx, pat_idx, led_n, busy, done} !== {7'(m_frame), 4'(m_pat), m_led, m_busy, m_done}) begin
                failures++;
                $display("FAIL pingpong f/p/led/b/d got %0d/%0d/%h/%b/%b exp %0d/%0d/%h/%b/%b", frame_idx, pat_idx, led_n, busy, done, m_frame, m_pat, m_led, m_busy, m_done);
            end
        end
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (dut_done_cnt - d0 != 1 || frame_idx !== 7'd0 || peak != 127) begin
            failures++;
            $display("FAIL pingpong_end pulses=%0d frame=%0d peak=%0d exp 1/0/127", dut_done_cnt - d0, frame_idx, peak);
        end
        pingpong = 0;
    endtask
`endif

    initial begin
        rst = 1; start = 0; stop = 0; pause = 0; loop_en = 0; speed = 0; pat_sel = 0;
`ifdef LED_ANIM_PINGPONG_EN
        pingpong = 0;
`endif
        test_reset();
        test_loop();
        test_oneshot();
        test_pause();
        test_stop_start();
`ifdef LED_ANIM_PINGPONG_EN
        test_pingpong();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
